// File: rtl/ppe_hdr_ingress_buffer.sv
// ppe_hdr_ingress_buffer
// Captures the first HDR_FLITS flits of each incoming packet as a zero-filled
// header window, measures the packet length, and queues one descriptor per
// packet in a small FIFO for the parser. Also keeps packet/error statistics.
module ppe_hdr_ingress_buffer #(
  parameter int FLIT_W    = 256,
  parameter int HDR_FLITS = 4,
  parameter int DEPTH     = 2
) (
  input  logic                        cclk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_sop,
  input  logic                        in_eop,
  input  logic [FLIT_W-1:0]           in_data,
  input  logic [5:0]                  in_bytes,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [HDR_FLITS*FLIT_W-1:0] out_hdr,
  output logic [7:0]                  out_hdr_len,
  output logic [15:0]                 out_pkt_len,
  output logic                        out_trunc,
  output logic                        out_err,
  output logic [31:0]                 stat_pkt_cnt,
  output logic [15:0]                 stat_err_cnt
);

  localparam int FLIT_BYTES = FLIT_W / 8;
  localparam int HDR_BYTES  = HDR_FLITS * FLIT_BYTES;
  localparam int HW         = HDR_FLITS * FLIT_W;
  localparam int IDXW       = (HDR_FLITS > 1) ? $clog2(HDR_FLITS) : 1;
  localparam int PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW         = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CAPT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nextState;

  // Packet assembly registers
  logic [HW-1:0]   r_hdr;
  logic [15:0]     r_len;
  logic            r_err;
  logic [IDXW-1:0] r_flitIdx;

  // Descriptor FIFO storage
  logic [HW-1:0] r_fifoHdr    [DEPTH];
  logic [7:0]    r_fifoHdrLen [DEPTH];
  logic [15:0]   r_fifoPktLen [DEPTH];
  logic          r_fifoTrunc  [DEPTH];
  logic          r_fifoErr    [DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;

  // Statistics
  logic [31:0] r_pktCnt;
  logic [15:0] r_errCnt;

  // Handshake and control decode
  logic            w_acc;
  logic            w_pop;
  logic            w_start;
  logic            w_cont;
  logic            w_inPkt;
  logic            w_seqErr;
  logic            w_store;
  logic            w_push;
  logic            w_badBytes;
  logic [IDXW-1:0] w_storeIdx;

  // Next assembly values and descriptor fields
  logic [6:0]        w_validBytes;
  logic [FLIT_W-1:0] w_byteMask;
  logic [HW-1:0]     w_nextHdr;
  logic [16:0]       w_lenSum;
  logic [15:0]       w_nextLen;
  logic              w_nextErr;
  logic [IDXW-1:0]   w_nextIdx;
  logic [7:0]        w_descHdrLen;
  logic              w_descTrunc;
  logic [1:0]        w_errInc;
  logic [16:0]       w_errSum;

  function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign in_ready  = (r_count < CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_acc     = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // FSM state register
  always_ff @(posedge cclk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FSM next state: eop always returns to IDLE, a filled window moves to DRAIN
  always_comb begin
    w_nextState = r_state;
    if (w_inPkt) begin
      if (in_eop) begin
        w_nextState = IDLE;
      end else if (w_store && (w_storeIdx == IDXW'(HDR_FLITS - 1))) begin
        w_nextState = DRAIN;
      end else if (w_start) begin
        w_nextState = CAPT;
      end
    end
  end

  // FSM outputs: classify each accepted flit as start, continuation or protocol error
  always_comb begin
    w_start  = 1'b0;
    w_cont   = 1'b0;
    w_seqErr = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_start  = in_sop;
          w_seqErr = !in_sop;
        end
      end
      CAPT, DRAIN: begin
        if (w_acc) begin
          w_start  = in_sop;
          w_cont   = !in_sop;
          w_seqErr = in_sop;
        end
      end
      default: ;
    endcase
    w_inPkt    = w_start || w_cont;
    w_store    = w_start || (w_cont && (r_state == CAPT));
    w_storeIdx = w_start ? '0 : r_flitIdx;
    w_push     = w_inPkt && in_eop;
    w_badBytes = w_push && ((in_bytes == 6'd0) || (in_bytes > 6'(FLIT_BYTES)));
  end

  // Next header window, length and error flag for the flit being accepted
  always_comb begin
    w_validBytes = (in_eop && !w_badBytes) ? {1'b0, in_bytes} : 7'(FLIT_BYTES);
    w_byteMask   = '0;
    for (int b = 0; b < FLIT_BYTES; b++) begin
      w_byteMask[b*8 +: 8] = (7'(b) < w_validBytes) ? 8'hFF : 8'h00;
    end
    w_nextHdr = w_start ? '0 : r_hdr;
    for (int k = 0; k < HDR_FLITS; k++) begin
      if (w_store && (w_storeIdx == IDXW'(k))) begin
        w_nextHdr[k*FLIT_W +: FLIT_W] = in_data & w_byteMask;
      end
    end
    w_lenSum     = (w_start ? 17'd0 : {1'b0, r_len}) + 17'(w_validBytes);
    w_nextLen    = w_lenSum[16] ? 16'hFFFF : w_lenSum[15:0];
    w_nextErr    = (w_start ? 1'b0 : r_err) | w_badBytes;
    w_nextIdx    = w_storeIdx + IDXW'(1);
    w_descTrunc  = (w_nextLen > 16'(HDR_BYTES));
    w_descHdrLen = w_descTrunc ? 8'(HDR_BYTES) : w_nextLen[7:0];
  end

  // Assembly registers: load on each packet flit, clear once the descriptor is pushed
  always_ff @(posedge cclk or negedge reset) begin
    if (!reset) begin
      r_hdr     <= '0;
      r_len     <= '0;
      r_err     <= 1'b0;
      r_flitIdx <= '0;
    end else if (w_push) begin
      r_hdr     <= '0;
      r_len     <= '0;
      r_err     <= 1'b0;
      r_flitIdx <= '0;
    end else if (w_inPkt) begin
      r_hdr <= w_nextHdr;
      r_len <= w_nextLen;
      r_err <= w_nextErr;
      if (w_store) begin
        r_flitIdx <= w_nextIdx;
      end
    end
  end

  // Descriptor FIFO: write on eop, read on parser handshake, count tracks occupancy
  always_ff @(posedge cclk or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < DEPTH; d++) begin
        r_fifoHdr[d]    <= '0;
        r_fifoHdrLen[d] <= '0;
        r_fifoPktLen[d] <= '0;
        r_fifoTrunc[d]  <= 1'b0;
        r_fifoErr[d]    <= 1'b0;
      end
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifoHdr[r_wrPtr]    <= w_nextHdr;
        r_fifoHdrLen[r_wrPtr] <= w_descHdrLen;
        r_fifoPktLen[r_wrPtr] <= w_nextLen;
        r_fifoTrunc[r_wrPtr]  <= w_descTrunc;
        r_fifoErr[r_wrPtr]    <= w_nextErr;
        r_wrPtr               <= ptrInc(r_wrPtr);
      end
      if (w_pop) begin
        r_rdPtr <= ptrInc(r_rdPtr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // One flit can raise both a sequencing error and an illegal byte count
  always_comb begin
    w_errInc = {1'b0, w_seqErr} + {1'b0, w_badBytes};
    w_errSum = {1'b0, r_errCnt} + 17'(w_errInc);
  end

  // Statistics: packet count wraps, error count saturates
  always_ff @(posedge cclk or negedge reset) begin
    if (!reset) begin
      r_pktCnt <= '0;
      r_errCnt <= '0;
    end else begin
      if (w_push) begin
        r_pktCnt <= r_pktCnt + 32'd1;
      end
      r_errCnt <= w_errSum[16] ? 16'hFFFF : w_errSum[15:0];
    end
  end

  // Head descriptor drives the outputs; zero whenever the FIFO is empty
  always_comb begin
    out_hdr     = '0;
    out_hdr_len = '0;
    out_pkt_len = '0;
    out_trunc   = 1'b0;
    out_err     = 1'b0;
    if (out_valid) begin
      out_hdr     = r_fifoHdr[r_rdPtr];
      out_hdr_len = r_fifoHdrLen[r_rdPtr];
      out_pkt_len = r_fifoPktLen[r_rdPtr];
      out_trunc   = r_fifoTrunc[r_rdPtr];
      out_err     = r_fifoErr[r_rdPtr];
    end
  end

  assign stat_pkt_cnt = r_pktCnt;
  assign stat_err_cnt = r_errCnt;

endmodule

// File: tb/tb_ppe_hdr_ingress_buffer.sv
// tb_ppe_hdr_ingress_buffer
// Drives packets into ppe_hdr_ingress_buffer and compares every delivered
// descriptor against an independently built expected descriptor queue.
module tb_ppe_hdr_ingress_buffer;

  localparam int FLIT_W    = 256;
  localparam int HDR_FLITS = 4;
  localparam int DEPTH     = 2;
  localparam int HW        = FLIT_W * HDR_FLITS;

  logic                 cclk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_sop;
  logic                 in_eop;
  logic [FLIT_W-1:0]    in_data;
  logic [5:0]           in_bytes;
  logic                 out_valid;
  logic                 out_ready;
  logic [HW-1:0]        out_hdr;
  logic [7:0]           out_hdr_len;
  logic [15:0]          out_pkt_len;
  logic                 out_trunc;
  logic                 out_err;
  logic [31:0]          stat_pkt_cnt;
  logic [15:0]          stat_err_cnt;

  typedef struct {
    logic [HW-1:0] hdr;
    logic [7:0]    hdrLen;
    logic [15:0]   pktLen;
    logic          trunc;
    logic          err;
  } expDesc_t;

  expDesc_t sb[$];
  expDesc_t monExp;
  int checks = 0;
  int errors = 0;
  int expPkt = 0;
  int expErr = 0;

  ppe_hdr_ingress_buffer #(
    .FLIT_W(FLIT_W),
    .HDR_FLITS(HDR_FLITS),
    .DEPTH(DEPTH)
  ) dut (
    .cclk(cclk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_sop(in_sop),
    .in_eop(in_eop),
    .in_data(in_data),
    .in_bytes(in_bytes),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_hdr(out_hdr),
    .out_hdr_len(out_hdr_len),
    .out_pkt_len(out_pkt_len),
    .out_trunc(out_trunc),
    .out_err(out_err),
    .stat_pkt_cnt(stat_pkt_cnt),
    .stat_err_cnt(stat_err_cnt)
  );

  // 100 MHz core clock
  always #5 cclk = ~cclk;

  // Every comparison funnels through here
  task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Byte b of flit f in a packet with the given seed
  function automatic logic [FLIT_W-1:0] flitData(input int seed, input int f);
    logic [FLIT_W-1:0] d;
    for (int b = 0; b < FLIT_W / 8; b++) begin
      d[b*8 +: 8] = 8'(seed + f * 32 + b);
    end
    return d;
  endfunction

  // Present one flit and hold it until accepted, with a bounded wait
  task automatic driveFlit(input logic sop, input logic eop, input logic [FLIT_W-1:0] data, input logic [5:0] bytes);
    bit acc = 1'b0;
    int budget = 0;
    in_valid = 1'b1;
    in_sop   = sop;
    in_eop   = eop;
    in_data  = data;
    in_bytes = bytes;
    while (!acc && budget < 200) begin
      @(negedge cclk);
      acc = in_ready;
      @(posedge cclk);
      #1;
      budget++;
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    if (!acc) checkOutput("flitTimeout", 256'(0), 256'(1));
  endtask

  // Build the expected descriptor for a clean packet, queue it, then drive the flits
  task automatic applyStimulus(input int nFlits, input int lastBytes, input int seed);
    expDesc_t d;
    int eff;
    int len;
    logic [7:0] byteVal;
    bit illegal;
    illegal = (lastBytes == 0) || (lastBytes > 32);
    eff = illegal ? 32 : lastBytes;
    len = (nFlits - 1) * 32 + eff;
    d.pktLen = (len > 65535) ? 16'hFFFF : 16'(len);
    d.hdrLen = (len > 128) ? 8'd128 : 8'(len);
    d.trunc  = (len > 128);
    d.err    = illegal;
    d.hdr    = '0;
    for (int f = 0; f < nFlits && f < HDR_FLITS; f++) begin
      for (int b = 0; b < 32; b++) begin
        byteVal = 8'(seed + f * 32 + b);
        if (f == nFlits - 1 && b >= eff) byteVal = 8'h00;
        d.hdr[(f * 32 + b) * 8 +: 8] = byteVal;
      end
    end
    sb.push_back(d);
    expPkt++;
    if (illegal) expErr++;
    for (int f = 0; f < nFlits; f++) begin
      driveFlit(f == 0, f == nFlits - 1, flitData(seed, f), 6'(lastBytes));
    end
  endtask

  // Statistics against the bench's running totals
  task automatic checkStats(input string tag);
    checkOutput({tag, "_pktCnt"}, 256'(stat_pkt_cnt), 256'(expPkt));
    checkOutput({tag, "_errCnt"}, 256'(stat_err_cnt), 256'(expErr));
  endtask

  // Wait until every queued descriptor has been delivered
  task automatic waitDrain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge cclk);
      n++;
    end
    #1;
    if (sb.size() != 0) begin
      checkOutput({tag, "_drainTimeout"}, 256'(sb.size()), 256'(0));
      sb.delete();
    end
  endtask

  // Scoreboard monitor: compare the head descriptor every cycle it is valid, pop on handshake
  always @(negedge cclk) begin
    if (reset === 1'b1 && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpectedDesc", 256'(1), 256'(0));
      end else begin
        monExp = sb[0];
        for (int k = 0; k < HDR_FLITS; k++) begin
          checkOutput($sformatf("hdrFlit%0d", k), out_hdr[k*FLIT_W +: FLIT_W], monExp.hdr[k*FLIT_W +: FLIT_W]);
        end
        checkOutput("hdrLen", 256'(out_hdr_len), 256'(monExp.hdrLen));
        checkOutput("pktLen", 256'(out_pkt_len), 256'(monExp.pktLen));
        checkOutput("trunc", 256'(out_trunc), 256'(monExp.trunc));
        checkOutput("err", 256'(out_err), 256'(monExp.err));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence
  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    in_data   = '0;
    in_bytes  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge cclk);
    #1;
    checkOutput("rstValid", 256'(out_valid), 256'(0));
    checkOutput("rstReady", 256'(in_ready), 256'(1));
    checkOutput("rstPktLen", 256'(out_pkt_len), 256'(0));
    checkOutput("rstHdr", out_hdr[255:0], 256'(0));
    checkStats("rst");
    @(negedge cclk);
    reset = 1'b1;
    @(posedge cclk);
    #1;

    $display("[TB] single-flit packet");
    applyStimulus(1, 20, 0);
    checkOutput("t1Latency", 256'(out_valid), 256'(1));
    checkStats("t1");
    waitDrain("t1");

    $display("[TB] six-flit truncated packet");
    applyStimulus(6, 8, 3);
    checkOutput("t2InReady", 256'(in_ready), 256'(1));
    waitDrain("t2");
    checkStats("t2");

    $display("[TB] backpressure with full FIFO");
    out_ready = 1'b0;
    applyStimulus(1, 4, 10);
    applyStimulus(1, 32, 20);
    checkOutput("t3Full", 256'(in_ready), 256'(0));
    fork
      applyStimulus(1, 17, 30);
      begin
        repeat (4) @(negedge cclk);
        checkOutput("t3Stall", 256'(in_ready), 256'(0));
        checkOutput("t3HeldValid", 256'(out_valid), 256'(1));
        @(posedge cclk);
        #1;
        out_ready = 1'b1;
      end
    join
    waitDrain("t3");
    checkStats("t3");

    $display("[TB] protocol errors and restart");
    driveFlit(1'b0, 1'b1, flitData(1, 0), 6'd32);
    driveFlit(1'b1, 1'b0, flitData(2, 0), 6'd0);
    driveFlit(1'b0, 1'b0, flitData(2, 1), 6'd0);
    expErr += 2;
    applyStimulus(3, 10, 77);
    waitDrain("t4");
    checkStats("t4");

    $display("[TB] illegal eop byte counts");
    applyStimulus(2, 0, 40);
    applyStimulus(1, 40, 50);
    waitDrain("t5");
    checkStats("t5");

    $display("[TB] reset during drain");
    out_ready = 1'b0;
    applyStimulus(1, 16, 5);
    for (int f = 0; f < 5; f++) begin
      driveFlit(f == 0, 1'b0, flitData(60, f), 6'd0);
    end
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t6Valid", 256'(out_valid), 256'(0));
    checkOutput("t6PktCnt", 256'(stat_pkt_cnt), 256'(0));
    checkOutput("t6ErrCnt", 256'(stat_err_cnt), 256'(0));
    checkOutput("t6PktLen", 256'(out_pkt_len), 256'(0));
    sb.delete();
    expPkt = 0;
    expErr = 0;
    @(negedge cclk);
    reset = 1'b1;
    out_ready = 1'b1;
    @(posedge cclk);
    #1;
    applyStimulus(2, 32, 9);
    waitDrain("t6");
    checkStats("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
